// File: rtl/axil_pkg.sv
// ============================================================================
// Module   : axil_pkg
// Purpose  : Shared AXI4-Lite definitions for the axil_master initiator:
//            response codes, default protection value and the FSM state type.
// Macros   : AXIL_MASTER_TIMEOUT_EN adds the sticky ERR state to the enum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RESP         = 3'd5
`ifdef AXIL_MASTER_TIMEOUT_EN
    ,
    ERR          = 3'd6
`endif
  } axil_master_state_t;

endpackage

`default_nettype wire

// File: rtl/axil_master.sv
// ============================================================================
// Module   : axil_master
// Purpose  : AXI4-Lite initiator. Turns a single-beat command/response
//            handshake into AW/W/B or AR/R channel traffic, one transaction
//            outstanding at a time. Every output is driven from a register.
// Ports    : clk, rst (asynchronous, active-low)
//            cmd_*   : command in  (valid/ready, write, addr, wdata, wstrb)
//            rsp_*   : response out (valid/ready, write, rdata, resp)
//            m_axil_*: AXI4-Lite master channels AW, W, B, AR, R
// Macros   : AXIL_MASTER_TIMEOUT_EN - response timeout with a sticky ERR
//            state; once it fires, cmd_ready stays low until reset.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axil_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || (STRB_WIDTH != DATA_WIDTH / 8) ||
      (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("axil_master: unsupported DATA_WIDTH/STRB_WIDTH/TIMEOUT_CYCLES");
  end

  axil_master_state_t    r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb, w_wstrb;
  logic                  r_write, w_write;
  logic                  r_aw_done, w_aw_done;
  logic                  r_w_done, w_w_done;
  logic                  r_cmd_ready, w_cmd_ready;
  logic                  r_awvalid, w_awvalid;
  logic                  r_wvalid, w_wvalid;
  logic                  r_bready, w_bready;
  logic                  r_arvalid, w_arvalid;
  logic                  r_rready, w_rready;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
  logic [1:0]            r_rsp_resp, w_rsp_resp;
  logic                  w_accept;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [c_CNT_W-1:0] r_cnt, w_cnt;
  logic               w_busy, w_final_hs, w_timeout;
`endif

  // cmd_ready is only ever high in IDLE, so it doubles as the IDLE qualifier.
  assign w_accept = cmd_valid & r_cmd_ready;

  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_write     = r_write;
    w_aw_done   = r_aw_done;
    w_w_done    = r_w_done;
    w_cmd_ready = 1'b0;
    w_awvalid   = r_awvalid;
    w_wvalid    = r_wvalid;
    w_bready    = r_bready;
    w_arvalid   = r_arvalid;
    w_rready    = r_rready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_resp  = r_rsp_resp;

    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (w_accept) begin
          w_cmd_ready = 1'b0;
          w_addr      = cmd_addr;
          w_wdata     = cmd_wdata;
          w_wstrb     = cmd_wstrb;
          w_write     = cmd_write;
          if (cmd_write) begin
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_aw_done = 1'b0;
            w_w_done  = 1'b0;
            w_state   = WR_ADDR_DATA;
          end else begin
            w_arvalid = 1'b1;
            w_state   = RD_ADDR;
          end
        end
      end

      WR_ADDR_DATA: begin
        // AW and W retire independently; each valid drops after its own
        // handshake and the done flags remember which side has finished.
        if (r_awvalid && m_axil_awready) begin
          w_awvalid = 1'b0;
          w_aw_done = 1'b1;
        end
        if (r_wvalid && m_axil_wready) begin
          w_wvalid = 1'b0;
          w_w_done = 1'b1;
        end
        if (w_aw_done && w_w_done) begin
          w_bready = 1'b1;
          w_state  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axil_bvalid) begin
          w_bready    = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_resp  = m_axil_bresp;
          w_rsp_rdata = '0;
          w_state     = RESP;
        end
      end

      RD_ADDR: begin
        if (m_axil_arready) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axil_rvalid) begin
          w_rready    = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_resp  = m_axil_rresp;
          w_rsp_rdata = m_axil_rdata;
          w_state     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
          w_state     = IDLE;
        end
      end

`ifdef AXIL_MASTER_TIMEOUT_EN
      ERR: begin
        // One error response, then parked here until reset.
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid = 1'b0;
        end
      end
`endif

      default: begin
        w_state = IDLE;
      end
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    w_busy     = (r_state == WR_ADDR_DATA) || (r_state == WR_RESP) ||
                 (r_state == RD_ADDR)      || (r_state == RD_DATA);
    // A B/R handshake in the expiry cycle wins over the timeout.
    w_final_hs = ((r_state == WR_RESP) && m_axil_bvalid) ||
                 ((r_state == RD_DATA) && m_axil_rvalid);
    // r_cnt holds the number of cycles elapsed since the accept cycle.
    w_timeout  = w_busy && !w_final_hs &&
                 (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    w_cnt      = r_cnt;
    if (w_accept) begin
      w_cnt = c_CNT_W'(1);
    end else if (r_state == IDLE) begin
      w_cnt = '0;
    end else if (w_busy) begin
      w_cnt = r_cnt + 1'b1;
    end
    if (w_timeout) begin
      w_awvalid   = 1'b0;
      w_wvalid    = 1'b0;
      w_bready    = 1'b0;
      w_arvalid   = 1'b0;
      w_rready    = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_resp  = AXIL_RESP_DECERR;
      w_rsp_rdata = '0;
      w_state     = ERR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_write     <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXIL_RESP_OKAY;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_write     <= w_write;
      r_aw_done   <= w_aw_done;
      r_w_done    <= w_w_done;
      r_cmd_ready <= w_cmd_ready;
      r_awvalid   <= w_awvalid;
      r_wvalid    <= w_wvalid;
      r_bready    <= w_bready;
      r_arvalid   <= w_arvalid;
      r_rready    <= w_rready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_resp  <= w_rsp_resp;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt;
    end
  end
`endif

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_write      = r_write;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_resp       = r_rsp_resp;
  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = AXIL_PROT_DEFAULT;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = AXIL_PROT_DEFAULT;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;

endmodule

`default_nettype wire

// File: doc/axil_master.md
Name: axil_master

Overview:
- AXI4-Lite initiator. Converts a simple single-beat command/response interface into AXI-Lite AW/W/B and AR/R channel traffic.
- Counterpart of axil_ram and other AXI-Lite slaves. Drives their s_axil_* ports in benches and in register-access paths.
- One transaction outstanding at a time.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width; must be 32 or 64.
- ADDR_WIDTH, 5, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; derived, not overridden.
- TIMEOUT_CYCLES, 256, response timeout; used only with the optional feature; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  write byte enables.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP value.
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1; m_axil_awready  in  1.
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1; m_axil_wready  in  1.
- m_axil_bresp  in  2; m_axil_bvalid  in  1; m_axil_bready  out  1.
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1; m_axil_arready  in  1.
- m_axil_rdata  in  DATA_WIDTH; m_axil_rresp  in  2; m_axil_rvalid  in  1; m_axil_rready  out  1.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, except cmd_ready, which is 1 once reset is released. Reset is IDLE.
- awprot and arprot are always 3'b000.
- All outputs are registered.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready=1.
  - On accept, latch addr, wdata, wstrb and write into registers.
  - Write: next cycle awvalid=1 and wvalid=1 together; go to WR_ADDR_DATA.
  - Read: next cycle arvalid=1; go to RD_ADDR.
- WR_ADDR_DATA: aw and w complete independently.
  - Each valid drops the cycle after its own handshake (aw_done and w_done flags).
  - Both handshakes in the same cycle go directly to WR_RESP.
  - Otherwise go to WR_RESP the cycle after the later handshake.
  - Payload is stable while valid is high.
- WR_RESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0, go to RESP.
- RD_ADDR: arvalid held until arready. Then arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, go to RESP.
- RESP: rsp_valid=1, with rsp fields stable, until rsp_ready. The handshake cycle returns to IDLE; cmd_ready=1 on the next cycle.
- cmd_ready=0 in every state except IDLE. No command is accepted while a response is pending.
- Latency with a zero-wait slave: write accept to rsp_valid is 3 cycles; read is 3 cycles.
- bready and rready are never asserted outside WR_RESP and RD_DATA. A slave holding bvalid or rvalid early is legal and is waited for.
- rsp_resp passes the slave value through unmodified (00, 01, 10, 11).
- Reset asserted mid-transaction: all valid/ready outputs clear immediately (asynchronously). The in-flight transaction is abandoned and no response is produced.

Optional Feature:
- Macro: AXIL_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES)+1 bits starts on command accept and clears on return to IDLE.
  - If it reaches TIMEOUT_CYCLES before the B or R handshake, drop all m_axil valids/readies and enter a sticky ERR state.
  - ERR presents one response with rsp_resp=2'b11 and rsp_rdata=0.
  - After that handshake, cmd_ready stays 0 until reset.
- Undefined: no counter and no ERR state. The block waits indefinitely.

Decomposition:
- Shared package axil_pkg:
  - response codes AXIL_RESP_OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - prot default 3'b000;
  - FSM state enum axil_master_state_t.
- No sub-module; the timeout counter is an internal ifdef block. Single module.

Test Plan:
- With axil_ram as slave: write addr 0x04, data 0xDEADBEEF, wstrb 4'hF -> rsp_write=1, rsp_resp=00. Then read 0x04 -> rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Partial write addr 0x04, data 0x0000CAFE, wstrb 4'b0011 -> a following read returns 0xDEADCAFE.
- Stub slave with awready delayed 3 cycles and wready immediate -> wvalid high for exactly 1 cycle, awvalid for 4 cycles, bready only after both handshakes. Same-cycle aw/w handshake -> WR_RESP the next cycle.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_valid and rsp fields stable, cmd_ready=0, no new AW/AR issued. cmd_ready=1 the cycle after the handshake.
- rst driven low mid-cycle while awvalid=1 -> awvalid, wvalid, bready go to 0 without waiting for clk. After release, cmd_ready=1 and a read of 0x08 completes normally.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts bvalid -> rsp_valid rises 16 cycles after accept with rsp_resp=2'b11. Thereafter cmd_ready stays 0 until reset.
